alu_serial_ctrl: RTL and testbench
==================================

Name: alu_serial_ctrl

Overview:
- Sequencer that turns one parallel ALU request (A, B, op) into the serial frame stream the serial ALU expects on `sin`.
- Captures and decodes the ALU's reply on `sout`, then returns the result through a valid/ready response interface.
- Sits between parallel test/stimulus logic and the serial ALU DUT.
- Exactly one transaction is in flight at a time.

Parameters:
- TIMEOUT, 2000: maximum clk cycles to wait for a response start bit before aborting.
- CHECK_CRC, 1: when 1, the received data-response CRC3 is checked and reported in `rsp_crc_ok`; when 0, `rsp_crc_ok` is forced to 1.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- req_valid  in  1  request present.
- req_ready  out  1  controller can accept a request.
- req_a  in  32  operand A.
- req_b  in  32  operand B.
- req_op  in  3  ALU opcode.
- sin  out  1  serial line to the ALU; idle high.
- sout  in  1  serial line from the ALU; idle high.
- rsp_valid  out  1  response present.
- rsp_ready  in  1  consumer accepts the response.
- rsp_c  out  32  result C.
- rsp_flags  out  4  ALU flags {carry, overflow, zero, negative}.
- rsp_crc_ok  out  1  received CRC3 matched.
- rsp_err  out  1  ALU returned an error frame.
- rsp_err_flags  out  6  error-frame flags.
- rsp_timeout  out  1  no response arrived within TIMEOUT.
- busy  out  1  transaction in progress (any state other than IDLE).

Behaviour:
- Reset (async, any state): state=IDLE, sin=1, req_ready=1, rsp_valid=0, busy=0; all rsp_* data outputs 0; counters cleared. Reset mid-frame abandons the transaction; sin is high on the first cycle after reset assertion.
- Frame format, 11 bits, MSB first, one bit per clk:
  - start bit 0;
  - type bit (0 = data, 1 = ctl);
  - 8 payload bits;
  - stop bit 1.
- Request handshake: a request is accepted when req_valid && req_ready. Operands are latched, req_ready drops the following cycle, and IDLE->SEND.
- SEND: 9 frames back-to-back with no idle bits between them:
  - B bytes, MSB byte first (4 data frames);
  - A bytes, MSB byte first (4 data frames);
  - one ctl frame with payload {0, op[2:0], crc4[3:0]}.
  - The first start bit is driven the cycle after acceptance; total SEND length is 99 cycles.
- CRC4: polynomial x^4+x+1, init 0, computed serially over the 68-bit vector {B, A, 1'b1, op}, MSB first.
- WAIT: sin=1. The timeout counter increments each cycle.
  - sout=0 seen -> RECV.
  - Counter reaches TIMEOUT -> DONE with rsp_timeout=1, all other rsp_* data 0.
- RECV (sampling of sout):
  - Each frame is 11 samples: start bit first, then type bit.
  - A ctl frame whose payload bit 7 is 1 is an error frame: rsp_err=1, rsp_err_flags=payload[6:1]; then go to DONE.
  - Otherwise, expect 4 data frames (C, MSB byte first) followed by a ctl frame with payload {0, flags[3:0], crc3[2:0]}.
  - CRC3: polynomial x^3+x+1, init 0, over {C, 1'b0, flags}.
  - Between frames, idle high bits are tolerated; each new frame starts at the next 0.
  - The timeout counter restarts at every frame start; a timeout mid-response also ends in DONE with rsp_timeout=1.
- DONE: rsp_valid=1 and all rsp_* outputs stable until rsp_valid && rsp_ready.
  - On that handshake: rsp_valid=0, IDLE, req_ready=1 the next cycle.
  - Back-to-back requests are allowed: req_valid may stay high.
- Exactly one of these holds per response:
  - normal result;
  - rsp_err=1;
  - rsp_timeout=1.
- A missing stop bit (sampled 0) is treated as an error response: rsp_err=1, rsp_err_flags=0.
- req_valid while busy is ignored (req_ready=0).
- sout activity during IDLE or SEND is ignored.

Test Plan:
- Reset check: assert rst mid-SEND (cycle 40) -> sin=1 immediately, req_ready=1, rsp_valid=0; a new request afterwards completes normally.
- Normal ADD: A=1, B=2, op=3'b100. sin must carry exactly 99 bits: 8 data frames 00000000/.../00000010/.../00000001, then a ctl frame {0,100,crc4}. Model replies C=3, flags=0 with correct CRC3 -> rsp_c=32'h3, rsp_flags=0, rsp_crc_ok=1, rsp_err=0.
- Error reply: model returns a ctl frame with payload 8'b1_100100_1 -> rsp_err=1, rsp_err_flags=6'b100100, rsp_c=0.
- Timeout: model silent, TIMEOUT=2000 -> rsp_timeout=1 exactly 2000 cycles after the last stop bit; rsp_valid held until rsp_ready.
- Bad CRC: model flips CRC3 bit 0 on C=32'hFFFFFFFF -> rsp_crc_ok=0, rsp_c=32'hFFFFFFFF.
- Backpressure and back-to-back: rsp_ready low for 50 cycles with req_valid held high -> no second acceptance until the handshake; the second request's first start bit appears the cycle after acceptance.

Source files
------------

// File: rtl/alu_serial_ctrl.sv
// rtl/alu_serial_ctrl.sv - parallel-to-serial ALU request sequencer with serial response capture
module alu_serial_ctrl #(
    parameter int TIMEOUT   = 2000,
    parameter bit CHECK_CRC = 1'b1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic [31:0] req_a,
    input  logic [31:0] req_b,
    input  logic [2:0]  req_op,
    output logic        sin,
    input  logic        sout,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [31:0] rsp_c,
    output logic [3:0]  rsp_flags,
    output logic        rsp_crc_ok,
    output logic        rsp_err,
    output logic [5:0]  rsp_err_flags,
    output logic        rsp_timeout,
    output logic        busy
);

    localparam int CW = $clog2(TIMEOUT + 1);

    typedef enum logic [2:0] {IDLE, SEND, WAIT, RECV, DONE} state_t;

    state_t        state;
    logic [98:0]   tx_sh;
    logic [6:0]    tx_cnt;
    logic [CW-1:0] to_cnt;
    logic [3:0]    rx_pos;
    logic [8:0]    rx_sh;
    logic [2:0]    rx_frames;
    logic [31:0]   rx_c;

    function automatic logic [10:0] frame(input logic t, input logic [7:0] p);
        return {1'b0, t, p, 1'b1};
    endfunction

    function automatic logic [3:0] crc4_calc(input logic [67:0] v);
        logic [3:0] c;
        logic       fb;
        c = 4'd0;
        for (int i = 67; i >= 0; i--) begin
            fb = c[3] ^ v[i];
            c  = {c[2:0], 1'b0} ^ {2'b00, fb, fb};
        end
        return c;
    endfunction

    function automatic logic [2:0] crc3_calc(input logic [36:0] v);
        logic [2:0] c;
        logic       fb;
        c = 3'd0;
        for (int i = 36; i >= 0; i--) begin
            fb = c[2] ^ v[i];
            c  = {c[1:0], 1'b0} ^ {1'b0, fb, fb};
        end
        return c;
    endfunction

    logic [3:0]  req_crc;
    logic [98:0] tx_frame;
    logic        rx_err;
    logic [5:0]  rx_err_flags;
    logic        rx_end;
    logic        rx_crc_ok;

    assign req_crc  = crc4_calc({req_b, req_a, 1'b1, req_op});
    assign tx_frame = {frame(1'b0, req_b[31:24]), frame(1'b0, req_b[23:16]),
                       frame(1'b0, req_b[15:8]),  frame(1'b0, req_b[7:0]),
                       frame(1'b0, req_a[31:24]), frame(1'b0, req_a[23:16]),
                       frame(1'b0, req_a[15:8]),  frame(1'b0, req_a[7:0]),
                       frame(1'b1, {1'b0, req_op, req_crc})};

    // Decision taken while the stop bit is on sout; rx_sh holds {type, payload}.
    always_comb begin
        rx_err       = 1'b0;
        rx_err_flags = 6'd0;
        if (!sout) begin
            rx_err = 1'b1;
        end else if (rx_sh[8] && rx_sh[7]) begin
            rx_err       = 1'b1;
            rx_err_flags = rx_sh[6:1];
        end else if (rx_frames != 3'd4) begin
            rx_err = rx_sh[8];
        end else begin
            rx_err = !rx_sh[8];
        end
        rx_end    = rx_err || (rx_frames == 3'd4);
        rx_crc_ok = !CHECK_CRC || (crc3_calc({rx_c, 1'b0, rx_sh[6:3]}) == rx_sh[2:0]);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state         <= IDLE;
            sin           <= 1'b1;
            req_ready     <= 1'b1;
            busy          <= 1'b0;
            rsp_valid     <= 1'b0;
            rsp_c         <= 32'd0;
            rsp_flags     <= 4'd0;
            rsp_crc_ok    <= 1'b0;
            rsp_err       <= 1'b0;
            rsp_err_flags <= 6'd0;
            rsp_timeout   <= 1'b0;
            tx_sh         <= '1;
            tx_cnt        <= 7'd0;
            to_cnt        <= '0;
            rx_pos        <= 4'd0;
            rx_sh         <= 9'd0;
            rx_frames     <= 3'd0;
            rx_c          <= 32'd0;
        end else begin
            case (state)
                IDLE: begin
                    if (req_valid) begin
                        sin       <= tx_frame[98];
                        tx_sh     <= {tx_frame[97:0], 1'b1};
                        tx_cnt    <= 7'd1;
                        req_ready <= 1'b0;
                        busy      <= 1'b1;
                        state     <= SEND;
                    end
                end
                SEND: begin
                    if (tx_cnt == 7'd99) begin
                        sin       <= 1'b1;
                        to_cnt    <= '0;
                        rx_frames <= 3'd0;
                        rx_c      <= 32'd0;
                        state     <= WAIT;
                    end else begin
                        sin    <= tx_sh[98];
                        tx_sh  <= {tx_sh[97:0], 1'b1};
                        tx_cnt <= tx_cnt + 7'd1;
                    end
                end
                WAIT: begin
                    if (!sout) begin
                        to_cnt <= '0;
                        rx_pos <= 4'd0;
                        state  <= RECV;
                    end else if (to_cnt == CW'(TIMEOUT - 1)) begin
                        rsp_valid     <= 1'b1;
                        rsp_timeout   <= 1'b1;
                        rsp_c         <= 32'd0;
                        rsp_flags     <= 4'd0;
                        rsp_crc_ok    <= 1'b0;
                        rsp_err       <= 1'b0;
                        rsp_err_flags <= 6'd0;
                        state         <= DONE;
                    end else begin
                        to_cnt <= to_cnt + 1'b1;
                    end
                end
                RECV: begin
                    rx_sh  <= {rx_sh[7:0], sout};
                    rx_pos <= rx_pos + 4'd1;
                    if (rx_pos == 4'd9) begin
                        if (rx_end) begin
                            rsp_valid     <= 1'b1;
                            rsp_timeout   <= 1'b0;
                            rsp_err       <= rx_err;
                            rsp_err_flags <= rx_err_flags;
                            rsp_c         <= rx_err ? 32'd0 : rx_c;
                            rsp_flags     <= rx_err ? 4'd0 : rx_sh[6:3];
                            rsp_crc_ok    <= !rx_err && rx_crc_ok;
                            state         <= DONE;
                        end else begin
                            rx_c      <= {rx_c[23:0], rx_sh[7:0]};
                            rx_frames <= rx_frames + 3'd1;
                            state     <= WAIT;
                        end
                    end
                end
                DONE: begin
                    if (rsp_ready) begin
                        rsp_valid <= 1'b0;
                        req_ready <= 1'b1;
                        busy      <= 1'b0;
                        state     <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_alu_serial_ctrl.sv
// tb/tb_alu_serial_ctrl.sv - directed bench for alu_serial_ctrl with a serial ALU reply model
module tb_alu_serial_ctrl;

    localparam int TO = 2000;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic [31:0] req_a = 32'd0;
    logic [31:0] req_b = 32'd0;
    logic [2:0]  req_op = 3'd0;
    logic        sin;
    logic        sout = 1'b1;
    logic        rsp_valid;
    logic        rsp_ready = 1'b0;
    logic [31:0] rsp_c;
    logic [3:0]  rsp_flags;
    logic        rsp_crc_ok;
    logic        rsp_err;
    logic [5:0]  rsp_err_flags;
    logic        rsp_timeout;
    logic        busy;

    int n_checks = 0;
    int n_err    = 0;

    alu_serial_ctrl #(.TIMEOUT(TO), .CHECK_CRC(1'b1)) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_a(req_a), .req_b(req_b), .req_op(req_op),
        .sin(sin), .sout(sout),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
        .rsp_c(rsp_c), .rsp_flags(rsp_flags), .rsp_crc_ok(rsp_crc_ok),
        .rsp_err(rsp_err), .rsp_err_flags(rsp_err_flags),
        .rsp_timeout(rsp_timeout), .busy(busy)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Polynomial long division; remainder equals the zero-init serial CRC.
    function automatic logic [3:0] m_crc4(input logic [67:0] v);
        logic [71:0] m;
        m = {v, 4'b0000};
        for (int i = 71; i >= 4; i--)
            if (m[i]) m[i-:5] = m[i-:5] ^ 5'b10011;
        return m[3:0];
    endfunction

    function automatic logic [2:0] m_crc3(input logic [36:0] v);
        logic [39:0] m;
        m = {v, 3'b000};
        for (int i = 39; i >= 3; i--)
            if (m[i]) m[i-:4] = m[i-:4] ^ 4'b1011;
        return m[2:0];
    endfunction

    function automatic logic [10:0] fr(input logic t, input logic [7:0] p);
        return {1'b0, t, p, 1'b1};
    endfunction

    function automatic logic [98:0] exp_send(input logic [31:0] a, input logic [31:0] b, input logic [2:0] op);
        logic [3:0] c;
        c = m_crc4({b, a, 1'b1, op});
        return {fr(1'b0, b[31:24]), fr(1'b0, b[23:16]), fr(1'b0, b[15:8]), fr(1'b0, b[7:0]),
                fr(1'b0, a[31:24]), fr(1'b0, a[23:16]), fr(1'b0, a[15:8]), fr(1'b0, a[7:0]),
                fr(1'b1, {1'b0, op, c})};
    endfunction

    task automatic start_req(input logic [31:0] a, input logic [31:0] b, input logic [2:0] op);
        req_a     = a;
        req_b     = b;
        req_op    = op;
        req_valid = 1'b1;
    endtask

    task automatic capture(output logic [98:0] got, output int lat);
        got = '1;
        lat = 0;
        do begin
            @(negedge clk);
            lat++;
        end while (sin !== 1'b0 && lat < 20);
        got[98] = sin;
        for (int i = 97; i >= 0; i--) begin
            @(negedge clk);
            got[i] = sin;
        end
    endtask

    task automatic tx_frame(input logic t, input logic [7:0] p, input logic stop, input int gap);
        logic [10:0] f;
        f = {1'b0, t, p, stop};
        for (int i = 10; i >= 0; i--) begin
            @(negedge clk);
            sout = f[i];
        end
        for (int i = 0; i < gap; i++) begin
            @(negedge clk);
            sout = 1'b1;
        end
    endtask

    task automatic reply_ok(input logic [31:0] c, input logic [3:0] fl, input logic flip);
        logic [2:0] crc;
        crc = m_crc3({c, 1'b0, fl}) ^ {2'b00, flip};
        tx_frame(1'b0, c[31:24], 1'b1, 2);
        tx_frame(1'b0, c[23:16], 1'b1, 0);
        tx_frame(1'b0, c[15:8],  1'b1, 3);
        tx_frame(1'b0, c[7:0],   1'b1, 1);
        tx_frame(1'b1, {1'b0, fl, crc}, 1'b1, 1);
    endtask

    task automatic wait_rsp(input string tag);
        int n;
        n = 0;
        while (rsp_valid !== 1'b1 && n < 100) begin
            @(negedge clk);
            n++;
        end
        chk(tag, rsp_valid, 1'b1);
    endtask

    task automatic handshake(input string tag);
        rsp_ready = 1'b1;
        @(negedge clk);
        rsp_ready = 1'b0;
        chk({tag, "_valid_drop"}, rsp_valid, 1'b0);
        chk({tag, "_req_ready"}, req_ready, 1'b1);
        chk({tag, "_busy"}, busy, 1'b0);
    endtask

    initial begin
        logic [98:0] got;
        logic [98:0] exp;
        int          lat;
        int          n;
        int          bad;

        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        chk("rst_sin", sin, 1'b1);
        chk("rst_req_ready", req_ready, 1'b1);
        chk("rst_rsp_valid", rsp_valid, 1'b0);
        chk("rst_busy", busy, 1'b0);
        chk("rst_rsp_data", {rsp_c, rsp_flags, rsp_crc_ok, rsp_err, rsp_err_flags, rsp_timeout}, 45'd0);

        // Reset in the middle of SEND, on a cycle where sin is low
        exp = exp_send(32'hFFFF_FFFF, 32'h0, 3'b010);
        start_req(32'hFFFF_FFFF, 32'h0, 3'b010);
        lat = 0;
        do begin
            @(negedge clk);
            lat++;
        end while (sin !== 1'b0 && lat < 20);
        chk("mid_first_start", lat, 1);
        repeat (40) @(negedge clk);
        chk("mid_sin_bit40", sin, exp[58]);
        chk("mid_busy", busy, 1'b1);
        rst       = 1'b1;
        req_valid = 1'b0;
        #1;
        chk("mid_rst_sin", sin, 1'b1);
        chk("mid_rst_req_ready", req_ready, 1'b1);
        chk("mid_rst_rsp_valid", rsp_valid, 1'b0);
        chk("mid_rst_busy", busy, 1'b0);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);

        // Normal ADD
        start_req(32'd1, 32'd2, 3'b100);
        capture(got, lat);
        req_valid = 1'b0;
        chk("add_latency", lat, 1);
        chk("add_frames", got, exp_send(32'd1, 32'd2, 3'b100));
        chk("add_req_ready_busy", req_ready, 1'b0);
        @(negedge clk);
        chk("add_sin_idle_after", sin, 1'b1);
        reply_ok(32'h3, 4'h0, 1'b0);
        wait_rsp("add_rsp_valid");
        chk("add_c", rsp_c, 32'h3);
        chk("add_flags", rsp_flags, 4'h0);
        chk("add_crc_ok", rsp_crc_ok, 1'b1);
        chk("add_err_to", {rsp_err, rsp_timeout}, 2'b00);
        handshake("add_hs");

        // Error frame reply
        start_req(32'h10, 32'h20, 3'b001);
        capture(got, lat);
        req_valid = 1'b0;
        chk("err_frames", got, exp_send(32'h10, 32'h20, 3'b001));
        tx_frame(1'b1, 8'b1_100100_1, 1'b1, 1);
        wait_rsp("err_rsp_valid");
        chk("err_flag", rsp_err, 1'b1);
        chk("err_err_flags", rsp_err_flags, 6'b100100);
        chk("err_c", rsp_c, 32'h0);
        chk("err_timeout", rsp_timeout, 1'b0);
        handshake("err_hs");

        // Timeout: silent model, count WAIT cycles before rsp_valid
        start_req(32'hCAFE_0001, 32'h5, 3'b111);
        capture(got, lat);
        req_valid = 1'b0;
        chk("to_frames", got, exp_send(32'hCAFE_0001, 32'h5, 3'b111));
        n = 0;
        @(negedge clk);
        while (rsp_valid !== 1'b1 && n < 3000) begin
            n++;
            @(negedge clk);
        end
        chk("to_cycles", n, TO);
        chk("to_timeout", rsp_timeout, 1'b1);
        chk("to_other_data", {rsp_c, rsp_flags, rsp_crc_ok, rsp_err, rsp_err_flags}, 44'd0);
        repeat (20) @(negedge clk);
        chk("to_held", {rsp_valid, rsp_timeout}, 2'b11);
        handshake("to_hs");

        // Bad CRC3
        start_req(32'h7FFF_FFFF, 32'h1, 3'b000);
        capture(got, lat);
        req_valid = 1'b0;
        chk("crc_frames", got, exp_send(32'h7FFF_FFFF, 32'h1, 3'b000));
        reply_ok(32'hFFFF_FFFF, 4'b1001, 1'b1);
        wait_rsp("crc_rsp_valid");
        chk("crc_ok_low", rsp_crc_ok, 1'b0);
        chk("crc_c", rsp_c, 32'hFFFF_FFFF);
        chk("crc_flags", rsp_flags, 4'b1001);
        chk("crc_err", rsp_err, 1'b0);
        handshake("crc_hs");

        // Backpressure with req_valid held, then back-to-back request
        start_req(32'h1122_3344, 32'h5566_7788, 3'b011);
        capture(got, lat);
        chk("bp_frames", got, exp_send(32'h1122_3344, 32'h5566_7788, 3'b011));
        start_req(32'h0BAD_F00D, 32'h00C0_FFEE, 3'b110);
        reply_ok(32'h1234_5678, 4'b0100, 1'b0);
        wait_rsp("bp_rsp_valid");
        bad = 0;
        repeat (50) begin
            @(negedge clk);
            if (req_ready !== 1'b0 || rsp_valid !== 1'b1 || sin !== 1'b1) bad++;
        end
        chk("bp_no_accept", bad, 0);
        chk("bp_c", rsp_c, 32'h1234_5678);
        chk("bp_flags_crc", {rsp_flags, rsp_crc_ok}, {4'b0100, 1'b1});
        rsp_ready = 1'b1;
        capture(got, lat);
        rsp_ready = 1'b0;
        req_valid = 1'b0;
        chk("b2b_latency", lat, 2);
        chk("b2b_frames", got, exp_send(32'h0BAD_F00D, 32'h00C0_FFEE, 3'b110));
        reply_ok(32'h8000_0000, 4'b0001, 1'b0);
        wait_rsp("b2b_rsp_valid");
        chk("b2b_c", rsp_c, 32'h8000_0000);
        chk("b2b_flags_crc", {rsp_flags, rsp_crc_ok, rsp_err, rsp_timeout}, {4'b0001, 3'b100});
        handshake("b2b_hs");

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
